// File: rtl/xbar_pkg.sv
// Shared constants, index-width helper and the forwarded-request record
// for the N x M req/ack crossbar.
package xbar_pkg;

   localparam int DEF_N_MASTERS = 2;
   localparam int DEF_N_SLAVES  = 2;
   localparam int DEF_ADDR_W    = 32;
   localparam int DEF_DATA_W    = 32;

   // Width of an index into n items; never less than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One master's request as seen at a slave port.
   typedef struct packed {
      logic                  req;
      logic [DEF_ADDR_W-1:0] addr;
      logic                  cmd;
      logic [DEF_DATA_W-1:0] wdata;
   } req_t;

endpackage

// File: rtl/xbar_nxm_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr,
// wrapping around, and reports it as one-hot plus binary index.
module rr_arbiter
   import xbar_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   int k;

   // Scan from the farthest slot back to ptr so the nearest requester wins.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      k       = 0;
      for (int i = N - 1; i >= 0; i--) begin
         k = (int'(ptr) + i) % N;
         if (req[k]) begin
            gnt     = '0;
            gnt[k]  = 1'b1;
            gnt_idx = IW'(k);
         end
      end
   end

endmodule

// File: rtl/xbar_nxm.sv
// N-master x M-slave req/ack crossbar. Each slave port owns a round-robin
// arbiter, a grant lock held from request to ack, and a one-cycle
// registered read-return path back to the acked master.
module xbar_nxm
   import xbar_pkg::*;
#(
   parameter int N_MASTERS = DEF_N_MASTERS,
   parameter int N_SLAVES  = DEF_N_SLAVES,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_MASTERS-1:0]          m_req,
   input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
   input  logic [N_MASTERS-1:0]          m_cmd,
   input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
   output logic [N_MASTERS-1:0]          m_ack,
   output logic [N_MASTERS*DATA_W-1:0]   m_rdata,
   output logic [N_MASTERS-1:0]          m_rvalid,
   output logic [N_SLAVES-1:0]           s_req,
   output logic [N_SLAVES*ADDR_W-1:0]    s_addr,
   output logic [N_SLAVES-1:0]           s_cmd,
   output logic [N_SLAVES*DATA_W-1:0]    s_wdata,
   input  logic [N_SLAVES-1:0]           s_ack,
   input  logic [N_SLAVES*DATA_W-1:0]    s_rdata
);

   localparam int SEL_W = $clog2(N_SLAVES);
   localparam int MIW   = idx_w(N_MASTERS);

   logic           sl_ack     [N_SLAVES];
   logic [MIW-1:0] sl_gnt_idx [N_SLAVES];
   logic           sl_rd_vld  [N_SLAVES];
   logic [MIW-1:0] sl_rd_own  [N_SLAVES];

   for (genvar s = 0; s < N_SLAVES; s++) begin : g_slv
      logic [N_MASTERS-1:0] tgt_req;
      logic [N_MASTERS-1:0] arb_gnt;
      logic [MIW-1:0]       arb_idx;
      logic                 gnt_vld;
      logic [MIW-1:0]       gnt_idx;
      logic                 sel_req;
      logic                 sel_cmd;
      logic [ADDR_W-1:0]    sel_addr;
      logic [DATA_W-1:0]    sel_wdata;
      logic                 fwd_ack;
      logic                 lock_vld_q, lock_vld_d;
      logic [MIW-1:0]       lock_own_q, lock_own_d;
      logic [MIW-1:0]       rr_ptr_q,   rr_ptr_d;
      logic                 rd_vld_q,   rd_vld_d;
      logic [MIW-1:0]       rd_own_q,   rd_own_d;

      // Requesters whose top address bits select this slave.
      always_comb begin
         tgt_req = '0;
         for (int m = 0; m < N_MASTERS; m++) begin
            tgt_req[m] = m_req[m] &&
                         (m_addr[m*ADDR_W + ADDR_W - 1 -: SEL_W] == SEL_W'(s));
         end
      end

      rr_arbiter #(.N(N_MASTERS), .IW(MIW)) u_arb (
         .req     (tgt_req),
         .ptr     (rr_ptr_q),
         .gnt     (arb_gnt),
         .gnt_idx (arb_idx)
      );

      // Grant from registered state only; s_ack never feeds back into it.
      always_comb begin
         gnt_vld    = lock_vld_q || (|arb_gnt);
         gnt_idx    = lock_vld_q ? lock_own_q : arb_idx;
         sel_req    = gnt_vld && m_req[gnt_idx];
         sel_cmd    = gnt_vld && m_cmd[gnt_idx];
         sel_addr   = gnt_vld ? m_addr[gnt_idx*ADDR_W +: ADDR_W] : '0;
         sel_wdata  = gnt_vld ? m_wdata[gnt_idx*DATA_W +: DATA_W] : '0;
         fwd_ack    = sel_req && s_ack[s];
         // Stay locked only while the owner keeps asking and has not been acked.
         lock_vld_d = sel_req && !s_ack[s];
         lock_own_d = lock_vld_q ? lock_own_q : arb_idx;
         rr_ptr_d   = rr_ptr_q;
         if (fwd_ack) begin
            rr_ptr_d = (int'(gnt_idx) == N_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
         end
         rd_vld_d   = fwd_ack && !sel_cmd;
         rd_own_d   = fwd_ack ? gnt_idx : rd_own_q;
      end

      // Lock, round-robin pointer and read-return registers for this slave.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
            rr_ptr_q   <= '0;
            rd_vld_q   <= 1'b0;
            rd_own_q   <= '0;
         end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_vld_q   <= rd_vld_d;
            rd_own_q   <= rd_own_d;
         end
      end

      assign s_req[s]                     = sel_req && !reset;
      assign s_cmd[s]                     = sel_cmd && !reset;
      assign s_addr[s*ADDR_W +: ADDR_W]   = reset ? '0 : sel_addr;
      assign s_wdata[s*DATA_W +: DATA_W]  = reset ? '0 : sel_wdata;

      assign sl_ack[s]     = fwd_ack && !reset;
      assign sl_gnt_idx[s] = gnt_idx;
      assign sl_rd_vld[s]  = rd_vld_q;
      assign sl_rd_own[s]  = rd_own_q;
   end

   // Route acks and read returns back to their masters; a master targets
   // one slave at a time, so at most one slave hits each master per cycle.
   always_comb begin
      m_ack    = '0;
      m_rvalid = '0;
      m_rdata  = '0;
      for (int s = 0; s < N_SLAVES; s++) begin
         for (int m = 0; m < N_MASTERS; m++) begin
            if (sl_ack[s] && (sl_gnt_idx[s] == MIW'(m))) begin
               m_ack[m] = 1'b1;
            end
            if (!reset && sl_rd_vld[s] && (sl_rd_own[s] == MIW'(m))) begin
               m_rvalid[m]                  = 1'b1;
               m_rdata[m*DATA_W +: DATA_W]  = s_rdata[s*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: tb/tb_xbar_nxm.sv
// Self-checking bench for xbar_nxm (4x4): directed scenarios followed by
// randomized traffic, all checked against a transaction-level model.
module tb_xbar_nxm;

   localparam int NM = 4;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NM-1:0]    m_req, m_cmd, m_ack, m_rvalid;
   logic [NM*AW-1:0] m_addr;
   logic [NM*DW-1:0] m_wdata, m_rdata;
   logic [NS-1:0]    s_req, s_cmd, s_ack;
   logic [NS*AW-1:0] s_addr;
   logic [NS*DW-1:0] s_wdata, s_rdata;

   xbar_nxm #(.N_MASTERS(NM), .N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk      (clk),
      .reset    (rst),
      .m_req    (m_req),
      .m_addr   (m_addr),
      .m_cmd    (m_cmd),
      .m_wdata  (m_wdata),
      .m_ack    (m_ack),
      .m_rdata  (m_rdata),
      .m_rvalid (m_rvalid),
      .s_req    (s_req),
      .s_addr   (s_addr),
      .s_cmd    (s_cmd),
      .s_wdata  (s_wdata),
      .s_ack    (s_ack),
      .s_rdata  (s_rdata)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model state per slave: current owner (-1 none), next master in turn,
   // master owed a read return next cycle (-1 none).
   int            lock_own [NS];
   int            rr       [NS];
   int            ret_pend [NS];
   logic [NM-1:0] last_ack;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int tgt(input int m);
      return int'(m_addr[m*AW + AW - 2 +: 2]);
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NS; s++) begin
         lock_own[s] = -1;
         rr[s]       = 0;
         ret_pend[s] = -1;
      end
   endtask

   task automatic set_m(input int m, input logic req, input logic [AW-1:0] addr,
                        input logic cmd, input logic [DW-1:0] wd);
      m_req[m]            = req;
      m_addr[m*AW +: AW]  = addr;
      m_cmd[m]            = cmd;
      m_wdata[m*DW +: DW] = wd;
   endtask

   task automatic new_txn(input int m);
      int sl;
      sl = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) sl = sl & 1;
      set_m(m, 1'b1, {2'(sl), 30'($urandom)}, 1'($urandom), $urandom);
   endtask

   // Called at a falling edge with inputs driven: predict, compare, advance.
   task automatic cycle();
      int            g, k;
      logic          ack;
      logic [NS-1:0]    e_sreq, e_scmd;
      logic [NS*AW-1:0] e_saddr;
      logic [NS*DW-1:0] e_swd;
      logic [NM-1:0]    e_ack, e_rv;
      logic [NM*DW-1:0] e_rd;
      #1;
      e_sreq = '0; e_scmd = '0; e_saddr = '0; e_swd = '0;
      e_ack  = '0; e_rv   = '0; e_rd    = '0;
      for (int s = 0; s < NS; s++) begin
         g   = -1;
         ack = 1'b0;
         if (!rst) begin
            if (ret_pend[s] >= 0) begin
               e_rv[ret_pend[s]]            = 1'b1;
               e_rd[ret_pend[s]*DW +: DW]   = s_rdata[s*DW +: DW];
            end
            if (lock_own[s] >= 0) g = lock_own[s];
            else begin
               for (int i = 0; i < NM; i++) begin
                  k = (rr[s] + i) % NM;
                  if (g < 0 && m_req[k] && tgt(k) == s) g = k;
               end
            end
         end
         if (g >= 0) begin
            e_sreq[s]            = m_req[g];
            e_scmd[s]            = m_cmd[g];
            e_saddr[s*AW +: AW]  = m_addr[g*AW +: AW];
            e_swd[s*DW +: DW]    = m_wdata[g*DW +: DW];
            ack                  = m_req[g] && s_ack[s];
            if (ack) e_ack[g] = 1'b1;
         end
         if (rst) begin
            lock_own[s] = -1;
            rr[s]       = 0;
            ret_pend[s] = -1;
         end else begin
            ret_pend[s] = -1;
            if (ack) begin
               if (!m_cmd[g]) ret_pend[s] = g;
               rr[s]       = (g + 1) % NM;
               lock_own[s] = -1;
            end else if (g >= 0) begin
               lock_own[s] = m_req[g] ? g : -1;
            end else begin
               lock_own[s] = -1;
            end
         end
      end
      chk("s_req",    s_req,    e_sreq);
      chk("s_cmd",    s_cmd,    e_scmd);
      chk("s_addr",   s_addr,   e_saddr);
      chk("s_wdata",  s_wdata,  e_swd);
      chk("m_ack",    m_ack,    e_ack);
      chk("m_rvalid", m_rvalid, e_rv);
      chk("m_rdata",  m_rdata,  e_rd);
      last_ack = e_ack;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      m_req = '0; m_cmd = '0; m_addr = '0; m_wdata = '0;
      s_ack = '0; s_rdata = '0;
      last_ack = '0;
      model_reset();
      @(negedge clk);

      // Reset forces outputs low even with live requests and acks.
      m_req = '1;
      s_ack = '1;
      for (int m = 0; m < NM; m++) m_addr[m*AW +: AW] = $urandom;
      #1;
      chk("rst_sreq", s_req, 0);
      chk("rst_mack", m_ack, 0);
      cycle();
      m_req = '0; s_ack = '0; rst = 1'b0;
      cycle();

      // Parallel write and read on different slaves, acked together.
      set_m(0, 1'b1, 32'h8000_0010, 1'b1, 32'h1111_0000);
      set_m(1, 1'b1, 32'h0000_0020, 1'b0, 32'h0);
      s_ack = 4'b0101;
      #1;
      chk("t1_sreq",  s_req, 4'b0101);
      chk("t1_saddr", s_addr[2*AW +: AW], 32'h8000_0010);
      chk("t1_mack",  m_ack, 4'b0011);
      cycle();
      m_req = '0; s_ack = '0;
      s_rdata[0 +: DW] = 32'hDEAD_BEEF;
      #1;
      chk("t1_rvalid", m_rvalid, 4'b0010);
      chk("t1_rdata",  m_rdata[DW +: DW], 32'hDEAD_BEEF);
      cycle();

      // Two readers on slave 0: owner holds through a stall, other waits.
      set_m(0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
      #1;
      chk("t2_grant0", s_addr[0 +: AW], 32'h0000_0040);
      cycle();
      set_m(1, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
      repeat (2) begin
         #1;
         chk("t2_block", m_ack, 0);
         chk("t2_hold",  s_addr[0 +: AW], 32'h0000_0040);
         cycle();
      end
      s_ack = 4'b0001;
      #1;
      chk("t2_ack0", m_ack, 4'b0001);
      cycle();
      m_req[0] = 1'b0;
      s_ack    = '0;
      #1;
      chk("t2_grant1", s_addr[0 +: AW], 32'h0000_0080);
      chk("t2_wait1",  m_ack, 0);
      cycle();
      s_ack = 4'b0001;
      #1;
      chk("t2_ack1", m_ack, 4'b0010);
      cycle();
      m_req = '0; s_ack = '0;

      // Reset while slave 1 is locked and a slave 3 read is owed.
      set_m(2, 1'b1, 32'hC000_0000, 1'b0, 32'h0);
      set_m(0, 1'b1, 32'h4000_0000, 1'b0, 32'h0);
      s_ack = 4'b1000;
      cycle();
      m_req[2] = 1'b0;
      s_ack    = '0;
      rst      = 1'b1;
      #1;
      chk("t5_rvalid", m_rvalid, 0);
      chk("t5_sreq",   s_req, 0);
      chk("t5_saddr",  s_addr, 0);
      chk("t5_mack",   m_ack, 0);
      cycle();
      cycle();
      rst   = 1'b0;
      m_req = '0;
      repeat (2) begin
         #1;
         chk("t5_norv", m_rvalid, 0);
         cycle();
      end

      // Four masters hammer slave 2 with immediate acks: strict rotation.
      for (int m = 0; m < NM; m++) set_m(m, 1'b1, 32'h8000_0000 | (m << 4), 1'b1, m);
      s_ack = 4'b0100;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("t3_order", m_ack, NM'(1) << (c % NM));
         cycle();
      end
      m_req = '0; s_ack = '0;

      // Owner drops req while locked: lock released, no ack, next master in.
      set_m(0, 1'b1, 32'h4000_0100, 1'b1, 32'hA5);
      cycle();
      set_m(1, 1'b1, 32'h4000_0200, 1'b1, 32'h5A);
      #1;
      chk("t6_hold", s_addr[AW +: AW], 32'h4000_0100);
      cycle();
      m_req[0] = 1'b0;
      #1;
      chk("t6_noack", m_ack, 0);
      chk("t6_sreq",  s_req[1], 0);
      cycle();
      s_ack = 4'b0010;
      #1;
      chk("t6_m1",  s_addr[AW +: AW], 32'h4000_0200);
      chk("t6_ack", m_ack, 4'b0010);
      cycle();
      m_req = '0; s_ack = '0;

      // Randomized traffic with occasional violations and resets.
      repeat (3000) begin
         for (int m = 0; m < NM; m++) begin
            if (m_req[m]) begin
               if (last_ack[m]) begin
                  m_req[m] = 1'($urandom_range(0, 1));
                  if (m_req[m]) new_txn(m);
               end else if ($urandom_range(0, 39) == 0) begin
                  m_req[m] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               new_txn(m);
            end
         end
         s_ack   = 4'($urandom);
         s_rdata = {$urandom, $urandom, $urandom, $urandom};
         rst     = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
